ysyx_22041461_if_stage: RTL

Instruction-fetch stage of the 64-bit five-stage RV64 pipeline. It sits directly upstream of ID and consumes the stall enable produced by the conflict detector. It owns the fetch PC and a single-outstanding valid/ready request to instruction memory. Responses go into a small fetch buffer, and the buffer head drives the registered IF→ID outputs. A redirect from EXE flushes the stage and discards any stale in-flight response.

---
 rtl/ysyx_22041461_if_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041461_if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem request, fetch buffer, IF->ID register.
// Define YSYX_22041461_MISALIGN_CHK_EN to add IF_exc and trap entries for misaligned redirect targets.
module ysyx_22041461_if_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IF_enable,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [63:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_out_valid
`ifdef YSYX_22041461_MISALIGN_CHK_EN
    ,
    output logic        IF_exc
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    logic [63:0]       fetch_pc, fetch_pc_nxt;
    logic [63:0]       req_addr, req_addr_nxt;
    logic              drop, drop_nxt;
    logic              park, park_nxt;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, cnt_after;
    logic [63:0]       buf_pc   [FIFO_DEPTH];
    logic [31:0]       buf_inst [FIFO_DEPTH];
`ifdef YSYX_22041461_MISALIGN_CHK_EN
    logic              buf_exc  [FIFO_DEPTH];
`endif

    logic [63:0]       redir_tgt;
    logic              mis;
    logic              hs, push, pop, buf_we;
    logic [PTR_W-1:0]  buf_widx;
    logic [63:0]       buf_wpc;
    logic [31:0]       buf_winst;

`ifdef YSYX_22041461_MISALIGN_CHK_EN
    assign redir_tgt = redirect_pc;
    assign mis       = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_tgt = redirect_pc & ~64'h3;
    assign mis       = 1'b0;
`endif

    assign hs        = (state == REQ) && imem_req_ready;
    assign push      = (state == WAIT) && imem_resp_valid && !drop && !redirect_valid;
    assign pop       = !redirect_valid && IF_enable && (count != '0);
    assign cnt_after = count + CNT_W'(push) - CNT_W'(pop);

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = req_addr;

    always_comb begin
        state_nxt    = state;
        drop_nxt     = drop;
        park_nxt     = park;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        case (state)
            IDLE: begin
                if (!redirect_valid && !park && (count < DEPTH_C)) begin
                    state_nxt    = REQ;
                    req_addr_nxt = fetch_pc;
                end
            end
            REQ: begin
                // A request already marked stale must not overwrite the redirect target with +4.
                if (hs) begin
                    state_nxt = WAIT;
                    if (!drop)
                        fetch_pc_nxt = req_addr + 64'd4;
                end
                if (redirect_valid)
                    drop_nxt = 1'b1;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    drop_nxt = 1'b0;
                    if (!redirect_valid && !park && (cnt_after < DEPTH_C)) begin
                        state_nxt    = REQ;
                        req_addr_nxt = fetch_pc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_nxt = redir_tgt;
            park_nxt     = mis;
        end
    end

    // A misaligned redirect lands its trap entry in slot 0 of the freshly flushed buffer.
    assign buf_we    = push || mis;
    assign buf_widx  = mis ? '0 : wr_ptr;
    assign buf_wpc   = mis ? redir_tgt : req_addr;
    assign buf_winst = mis ? 32'h0 : imem_resp_data;

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_pc[buf_widx]   <= buf_wpc;
            buf_inst[buf_widx] <= buf_winst;
`ifdef YSYX_22041461_MISALIGN_CHK_EN
            buf_exc[buf_widx]  <= mis;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            drop         <= 1'b0;
            park         <= 1'b0;
            fetch_pc     <= RESET_PC;
            req_addr     <= 64'h0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            IF_pc        <= 64'h0;
            IF_inst      <= 32'h0;
            IF_out_valid <= 1'b0;
`ifdef YSYX_22041461_MISALIGN_CHK_EN
            IF_exc       <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            drop     <= drop_nxt;
            park     <= park_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
            if (redirect_valid) begin
                rd_ptr       <= '0;
                wr_ptr       <= PTR_W'(mis);
                count        <= CNT_W'(mis);
                IF_out_valid <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= cnt_after;
                if (IF_enable) begin
                    IF_out_valid <= pop;
                    if (pop) begin
                        IF_pc   <= buf_pc[rd_ptr];
                        IF_inst <= buf_inst[rd_ptr];
`ifdef YSYX_22041461_MISALIGN_CHK_EN
                        IF_exc  <= buf_exc[rd_ptr];
`endif
                    end
                end
            end
        end
    end

endmodule
